// File: rtl/vga_scan_controller.sv
// 640x480@60 VGA raster generator: scans video RAM and drives sync and colour pins.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern selected by iTestMode.
module vga_scan_controller #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned ADDR_W    = 19
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [2:0]        iPixel,
  input  logic              iTestMode,
  output logic [ADDR_W-1:0] oReadAddress,
  output logic              oVGA_RED,
  output logic              oVGA_GREEN,
  output logic              oVGA_BLUE,
  output logic              oVGA_HSYNC,
  output logic              oVGA_VSYNC,
  output logic              oFrameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  typedef logic [HW-1:0] h_t;
  typedef logic [VW-1:0] v_t;

  localparam h_t H_LAST = h_t'(H_TOTAL - 1);
  localparam h_t H_VIS  = h_t'(H_VISIBLE);
  localparam h_t HS_BEG = h_t'(H_VISIBLE + H_FRONT);
  localparam h_t HS_LST = h_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam v_t V_LAST = v_t'(V_TOTAL - 1);
  localparam v_t V_VIS  = v_t'(V_VISIBLE);
  localparam v_t VS_BEG = v_t'(V_VISIBLE + V_FRONT);
  localparam v_t VS_LST = v_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);

  logic              toggle_q, toggle_d;
  h_t                h_q, h_d;
  v_t                v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              fs_q, fs_d;

  logic       tick;
  logic       visible;
  logic       wrap;
  logic [2:0] colour;

`ifdef VGA_TEST_PATTERN_EN
  localparam h_t BAR_W = h_t'(H_VISIBLE / 8);

  always_comb begin
    colour = iPixel;
    if (iTestMode) colour = 3'(h_q / BAR_W);
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = iTestMode;

  always_comb begin
    colour = iPixel;
  end
`endif

  always_comb begin
    toggle_d = ~toggle_q;
    h_d      = h_q;
    v_d      = v_q;
    addr_d   = addr_q;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    fs_d     = 1'b0;

    tick    = toggle_q;
    visible = (h_q < H_VIS) && (v_q < V_VIS);
    wrap    = (h_q == H_LAST) && (v_q == V_LAST);

    if (tick) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + h_t'(1);
      if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + v_t'(1);

      // Saturate on the last visible pixel so the address never leaves the frame buffer.
      if (wrap)                             addr_d = '0;
      else if (visible && addr_q != A_LAST) addr_d = addr_q + ADDR_W'(1);

      rgb_d = visible ? colour : 3'b000;
      hs_d  = !((h_q >= HS_BEG) && (h_q <= HS_LST));
      vs_d  = !((v_q >= VS_BEG) && (v_q <= VS_LST));
      fs_d  = wrap;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      toggle_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      h_q      <= h_d;
      v_q      <= v_d;
      addr_q   <= addr_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
    end
  end

  assign oReadAddress = addr_q;
  assign oVGA_RED     = rgb_q[2];
  assign oVGA_GREEN   = rgb_q[1];
  assign oVGA_BLUE    = rgb_q[0];
  assign oVGA_HSYNC   = hs_q;
  assign oVGA_VSYNC   = vs_q;
  assign oFrameStart  = fs_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: one full-size instance and one shrunken-timing instance,
// both checked every Clock against an arithmetic raster model.
module tb_vga_scan_controller;

  logic        Clock;
  logic        rst_b, rst_s;
  logic        tmode;
  logic [2:0]  key;
  logic [2:0]  pix_b, pix_s;
  logic [18:0] addr_b, addr_s;
  logic        r_b, g_b, bl_b, hs_b, vs_b, fs_b;
  logic        r_s, g_s, bl_s, hs_s, vs_s, fs_s;
  logic [31:0] pack_b, pack_s;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int kb          = 0;
  int ks          = 0;
  logic tm_b      = 1'b0;
  logic tm_s      = 1'b0;

  logic prev_hs_b  = 1'b1;
  int   last_fall_b = -1;
  logic prev_vs_s  = 1'b1;
  int   vrun       = 0;
  int   last_fs_s  = -1;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  // Video RAM stand-in: pixel content is a keyed hash of the address.
  function automatic logic [2:0] fpix(input int a, input logic [2:0] k);
    logic [31:0] x;
    x = a;
    return x[2:0] ^ x[5:3] ^ x[9:7] ^ k;
  endfunction

  assign pix_b = fpix(int'(addr_b), key);
  assign pix_s = fpix(int'(addr_s), key);

  vga_scan_controller dut_b (
    .Clock(Clock), .Reset(rst_b), .iPixel(pix_b), .iTestMode(tmode),
    .oReadAddress(addr_b), .oVGA_RED(r_b), .oVGA_GREEN(g_b), .oVGA_BLUE(bl_b),
    .oVGA_HSYNC(hs_b), .oVGA_VSYNC(vs_b), .oFrameStart(fs_b)
  );

  vga_scan_controller #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .Clock(Clock), .Reset(rst_s), .iPixel(pix_s), .iTestMode(tmode),
    .oReadAddress(addr_s), .oVGA_RED(r_s), .oVGA_GREEN(g_s), .oVGA_BLUE(bl_s),
    .oVGA_HSYNC(hs_s), .oVGA_VSYNC(vs_s), .oFrameStart(fs_s)
  );

  assign pack_b = {7'd0, addr_b, r_b, g_b, bl_b, hs_b, vs_b, fs_b};
  assign pack_s = {7'd0, addr_s, r_s, g_s, bl_s, hs_s, vs_s, fs_s};

  initial begin
    Clock = 1'b0;
    forever #10 Clock = ~Clock;
  end

  // Visible pixels strictly before raster position q, capped at the last frame address.
  function automatic int addr_of(input int hv, input int vv, input int ht, input int vt, input int q);
    int hq, vq, c;
    hq = q % ht;
    vq = (q / ht) % vt;
    c  = (vq < vv) ? vq * hv + ((hq < hv) ? hq : hv) : vv * hv;
    if (c > hv * vv - 1) c = hv * vv - 1;
    return c;
  endfunction

  // Expected outputs after k Clock edges since reset release; tm = iTestMode at the last tick.
  function automatic logic [31:0] model(input int hv, input int hf, input int hsw, input int hb,
                                        input int vv, input int vf, input int vsw, input int vb,
                                        input int k, input logic tm);
    int ht, vt, n, p, hp, vp, a;
    logic [2:0] rgb;
    logic hs, vs, fs;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    n  = k / 2;
    if (n == 0) return {7'd0, 19'd0, 3'b000, 1'b1, 1'b1, 1'b0};
    p  = n - 1;
    hp = p % ht;
    vp = (p / ht) % vt;
    hs = !(hp >= hv + hf && hp < hv + hf + hsw);
    vs = !(vp >= vv + vf && vp < vv + vf + vsw);
    if (hp < hv && vp < vv)
      rgb = (TP && tm) ? 3'((hp / (hv / 8)) % 8) : fpix(addr_of(hv, vv, ht, vt, p), key);
    else
      rgb = 3'b000;
    fs = (k % 2 == 0) && (n % (ht * vt) == 0);
    a  = addr_of(hv, vv, ht, vt, n);
    return {7'd0, a[18:0], rgb, hs, vs, fs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic tm_pre;
    tm_pre = tmode;
    @(posedge Clock);
    if (!rst_b) begin kb++; if (kb % 2 == 0) tm_b = tm_pre; end
    if (!rst_s) begin ks++; if (ks % 2 == 0) tm_s = tm_pre; end
    #1;
    cyc++;
    check("scan_big",   pack_b, model(640, 16, 96, 48, 480, 10, 2, 33, kb, tm_b));
    check("scan_small", pack_s, model(16, 2, 3, 3, 6, 1, 2, 1, ks, tm_s));
    if (prev_hs_b && !hs_b) begin
      if (last_fall_b >= 0) check("hsync_period", cyc - last_fall_b, 1600);
      last_fall_b = cyc;
    end
    prev_hs_b = hs_b;
    if (!vs_s) vrun++;
    if (!prev_vs_s && vs_s) begin
      check("vsync_width", vrun, 96);
      vrun = 0;
    end
    prev_vs_s = vs_s;
    if (fs_s) begin
      if (last_fs_s >= 0) check("frame_period", cyc - last_fs_s, 480);
      last_fs_s = cyc;
    end
    if ($urandom_range(0, 15) == 0) tmode = ~tmode;
  endtask

  typedef struct {
    int   k;
    logic hs;
    logic vs;
    int   addr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int guard;
    tbl[0]  = '{0,    1'b1, 1'b1, 0};
    tbl[1]  = '{1,    1'b1, 1'b1, 0};
    tbl[2]  = '{2,    1'b1, 1'b1, 1};
    tbl[3]  = '{1278, 1'b1, 1'b1, 639};
    tbl[4]  = '{1280, 1'b1, 1'b1, 640};
    tbl[5]  = '{1312, 1'b1, 1'b1, 640};
    tbl[6]  = '{1314, 1'b0, 1'b1, 640};
    tbl[7]  = '{1504, 1'b0, 1'b1, 640};
    tbl[8]  = '{1506, 1'b1, 1'b1, 640};
    tbl[9]  = '{1600, 1'b1, 1'b1, 640};
    tbl[10] = '{2878, 1'b1, 1'b1, 1279};
    tbl[11] = '{2880, 1'b1, 1'b1, 1280};

    rst_b = 1'b1;
    rst_s = 1'b1;
    tmode = 1'b0;
    key   = 3'($urandom);
    repeat (3) step();
    @(negedge Clock);
    rst_b = 1'b0;
    rst_s = 1'b0;

    for (int i = 0; i < 12; i++) begin
      while (kb < tbl[i].k) step();
      check($sformatf("tbl%0d_k%0d", i, tbl[i].k), {11'd0, hs_b, vs_b, addr_b},
            {11'd0, tbl[i].hs, tbl[i].vs, 19'(tbl[i].addr)});
    end
    while (kb < 3400) step();

    // Mid-line reset of the small instance at counter position (10,3).
    guard = 0;
    while (!(ks % 2 == 0 && (ks / 2) % 240 == 82) && guard < 1000) begin
      step();
      guard++;
    end
    if (guard >= 1000) check("seek_timeout", 32'd1, 32'd0);
    #4;
    rst_s = 1'b1;
    ks = 0;
    vrun = 0;
    prev_vs_s = 1'b1;
    last_fs_s = -1;
    #1;
    check("async_reset", pack_s, {7'd0, 19'd0, 3'b000, 1'b1, 1'b1, 1'b0});
    repeat (3) step();
    @(negedge Clock);
    rst_s = 1'b0;
    check("restart_addr", {13'd0, addr_s}, 32'd0);
    repeat (2) step();
    check("restart_first_tick", {13'd0, addr_s}, 32'd1);
    repeat (600) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
